calc_ctrl: RTL and testbench
============================

# calc_ctrl

Sequencing controller for the 4-digit signed calculator datapath. Accepts decoded keypad events (digits, sign toggle, operator, equals, clear), builds operands, drives the combinational ALU (16-bit signed a/b, 3-bit opcode: 0 clear, 1 add, 2 sub, 3 mul, 4 div, overflow flag for |result| > 9999 or divide-by-zero), captures its result, and presents a value and error flag to the display driver.

## Interface
- MAX_DIGITS, 4, maximum digits per operand entry (legal 1..4); further digits are ignored.
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_digit_valid  in  1  one-cycle pulse, digit key pressed.
- key_digit  in  4  digit value 0..9; values 10..15 ignored.
- key_neg  in  1  one-cycle pulse, toggle sign of current entry.
- key_op_valid  in  1  one-cycle pulse, operator key pressed.
- key_op  in  3  operator 1..4 (ALU encoding); 0 and 5..7 ignored.
- key_eq  in  1  one-cycle pulse, equals.
- key_clr  in  1  one-cycle pulse, clear all.
- alu_a  out  16  signed operand A to ALU, registered.
- alu_b  out  16  signed operand B to ALU, registered.
- alu_opcode  out  3  opcode to ALU, registered; 0 except in EXEC.
- alu_out  in  16  signed ALU result.
- alu_ovf  in  1  ALU overflow/error flag.
- disp_value  out  16  signed value for display, registered.
- disp_err  out  1  error indicator, registered.
- busy  out  1  high while in EXEC.

## Operation
- States: ENTER_A, ENTER_B, EXEC, SHOW, ERR. Reset -> ENTER_A.
- Registers: entry (signed 16), entry_cnt (0..MAX_DIGITS), pend_op (3), result (signed 16).
- One event per cycle; priority clr > eq > op > neg > digit; lower-priority simultaneous pulses are dropped.
- Digit (ENTER_A/ENTER_B, entry_cnt < MAX_DIGITS): entry = entry*10 ± digit (sign follows entry sign), entry_cnt+1. At MAX_DIGITS: ignored.
- Neg (ENTER_A/ENTER_B): entry = -entry; a pending sign is kept when entry is 0 (sign flag register), applied to later digits.
- Op in ENTER_A: alu_a <= entry, pend_op <= key_op, clear entry/count/sign, -> ENTER_B.
- Op in ENTER_B with entry_cnt = 0: replace pend_op, stay.
- Op in ENTER_B with entry_cnt > 0: see Configuration.
- Eq in ENTER_B: alu_b <= entry (0 if no digits), -> EXEC. Eq in ENTER_A/SHOW/ERR: ignored.
- EXEC: alu_opcode = pend_op for exactly one cycle; next edge: if alu_ovf -> ERR, else result <= alu_out -> SHOW (or ENTER_B when chaining).
- SHOW: op -> alu_a <= result, pend_op <= key_op, -> ENTER_B; digit -> ENTER_A with entry = digit; neg -> ENTER_A with entry = -result, entry_cnt = MAX_DIGITS.
- ERR: all keys except clr ignored.
- Clr (any state, including EXEC): clear all registers, -> ENTER_A; in-flight result discarded.
- disp_value: entry in ENTER_A/ENTER_B, result in SHOW/EXEC, 0 in ERR. disp_err = 1 only in ERR.

## Timing
- Reset values: alu_a, alu_b, alu_opcode, disp_value = 0; disp_err, busy = 0; state ENTER_A.
- Key pulse sampled at edge t -> entry and disp_value updated after t.
- Eq sampled at edge t -> EXEC during cycle t..t+1 (busy = 1, alu_opcode valid) -> result captured at edge t+1; disp_value/disp_err valid after t+1. Eq-to-display latency 2 cycles.
- Keys other than clr arriving while busy are dropped, not queued.
- alu_out is sampled only on the edge leaving EXEC; values at other times are ignored.

## Configuration
- CALC_CHAIN_EN defined: op in ENTER_B with entry_cnt > 0 behaves as eq (alu_b <= entry, EXEC with pend_op), then on success alu_a <= alu_out, result <= alu_out, pend_op <= new op, -> ENTER_B with entry cleared; disp_value shows intermediate result until the first digit. Overflow -> ERR.
- Not defined: that op is ignored; only eq executes.

## Test plan
- Reset, keys 1,2,+,3,4,= -> alu_opcode = 1 for one cycle with alu_a = 12, alu_b = 34; disp_value = 46, disp_err = 0 two cycles after eq.
- 9,9,9,9,+,1,= -> ERR, disp_err = 1, disp_value = 0; then digit 5 ignored; clr -> ENTER_A, disp_value = 0, disp_err = 0.
- 5,/,= (no B digits) -> alu_b = 0, opcode 4, ERR.
- 1,2,3,4,5 -> disp_value = 1234; 7,neg,-,3,= -> -10.
- With CALC_CHAIN_EN: 2,+,3,*,4,= -> intermediate disp_value = 5, final 20; without macro the * key is dropped and result is 5.
- clr asserted in same cycle as eq, and separately during EXEC -> ENTER_A, busy = 0, disp_value = 0, no result captured.

Source files
------------

// File: rtl/calc_ctrl_if.sv
// calc_ctrl_if: bundle of keypad events, ALU operand/result bus and display
// outputs for the calculator sequencing controller.
//
// Handshake semantics: every key_* strobe is a single-cycle pulse sampled on
// the rising clock edge. There is no ready/back-pressure. At most one event is
// consumed per cycle, and events that cannot be used in the current state are
// dropped, not held. The ALU path is purely combinational. alu_a/alu_b/alu_opcode
// go out registered, and alu_out/alu_ovf are sampled only on the edge that
// leaves EXEC.
//
// Modports:
//   slave  - the controller (calc_ctrl): consumes keys and ALU result, drives
//            ALU operands, display value/error, busy and the debug state.
//   master - the environment (keypad decoder + ALU + display driver).
interface calc_ctrl_if;
  logic               key_digit_valid;
  logic [3:0]         key_digit;
  logic               key_neg;
  logic               key_op_valid;
  logic [2:0]         key_op;
  logic               key_eq;
  logic               key_clr;
  logic signed [15:0] alu_a;
  logic signed [15:0] alu_b;
  logic [2:0]         alu_opcode;
  logic signed [15:0] alu_out;
  logic               alu_ovf;
  logic signed [15:0] disp_value;
  logic               disp_err;
  logic               busy;
  logic [2:0]         dbg_state;

  modport slave (
    input  key_digit_valid, key_digit, key_neg, key_op_valid, key_op,
           key_eq, key_clr, alu_out, alu_ovf,
    output alu_a, alu_b, alu_opcode, disp_value, disp_err, busy, dbg_state
  );

  modport master (
    output key_digit_valid, key_digit, key_neg, key_op_valid, key_op,
           key_eq, key_clr, alu_out, alu_ovf,
    input  alu_a, alu_b, alu_opcode, disp_value, disp_err, busy, dbg_state
  );
endinterface

// File: rtl/calc_ctrl.sv
// calc_ctrl: sequencing controller for a 4-digit signed calculator.
// It builds operands from keypad events, launches one ALU operation per
// equals, and captures the result. It then presents a value and an error
// flag to the display.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - calc_ctrl_if.slave (keys in, ALU operands out, ALU result in,
//            disp_value/disp_err/busy out, dbg_state = current FSM state)
//
// Parameter MAX_DIGITS (1..4): digits accepted per operand entry.
//
// Optional feature macro CALC_CHAIN_EN: when defined, an operator pressed
// after B digits executes the pending operation. The result becomes the new
// A operand and entry of B starts again. When undefined, that operator key
// is ignored.
module calc_ctrl #(
  parameter int MAX_DIGITS = 4
) (
  input logic        clk,
  input logic        rst_n,
  calc_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_EXEC    = 3'd2,
    ST_SHOW    = 3'd3,
    ST_ERR     = 3'd4
  } state_e;

  state_e             state_q,   state_d;
  logic signed [15:0] entry_q,   entry_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               neg_q,     neg_d;     // sign of the current entry, kept even while entry is 0
  logic [2:0]         pend_op_q, pend_op_d;
  logic signed [15:0] result_q,  result_d;
  logic signed [15:0] alu_a_q,   alu_a_d;
  logic signed [15:0] alu_b_q,   alu_b_d;
  logic [2:0]         opcode_q,  opcode_d;
  logic signed [15:0] disp_q,    disp_d;
  logic               err_q,     err_d;
`ifdef CALC_CHAIN_EN
  logic               chain_q,    chain_d;    // current EXEC was launched by an operator key
  logic [2:0]         next_op_q,  next_op_d;  // operator that follows the chained result
  logic               show_res_q, show_res_d; // display the intermediate result until a digit arrives
`endif

  // One event per cycle: clr > eq > op > neg > digit.
  logic ev_clr, ev_eq, ev_op, ev_neg, ev_digit;
  logic op_legal, digit_legal;
  logic signed [15:0] digit_s;

  assign ev_clr   = bus.key_clr;
  assign ev_eq    = bus.key_eq       & ~ev_clr;
  assign ev_op    = bus.key_op_valid & ~bus.key_eq & ~ev_clr;
  assign ev_neg   = bus.key_neg      & ~bus.key_op_valid & ~bus.key_eq & ~ev_clr;
  assign ev_digit = bus.key_digit_valid & ~bus.key_neg & ~bus.key_op_valid &
                    ~bus.key_eq & ~ev_clr;

  assign op_legal    = (bus.key_op >= 3'd1) && (bus.key_op <= 3'd4);
  assign digit_legal = (bus.key_digit <= 4'd9);
  assign digit_s     = $signed({12'd0, bus.key_digit});

  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    pend_op_d = pend_op_q;
    result_d  = result_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    opcode_d  = 3'd0;
    disp_d    = disp_q;
    err_d     = 1'b0;
`ifdef CALC_CHAIN_EN
    chain_d    = chain_q;
    next_op_d  = next_op_q;
    show_res_d = show_res_q;
`endif

    if (ev_clr) begin
      // Clear wins everywhere, including EXEC: the in-flight result is dropped.
      state_d   = ST_ENTER_A;
      entry_d   = '0;
      cnt_d     = '0;
      neg_d     = 1'b0;
      pend_op_d = '0;
      result_d  = '0;
      alu_a_d   = '0;
      alu_b_d   = '0;
`ifdef CALC_CHAIN_EN
      chain_d    = 1'b0;
      next_op_d  = '0;
      show_res_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_ENTER_A, ST_ENTER_B: begin
          if (ev_eq) begin
            if (state_q == ST_ENTER_B) begin
              alu_b_d  = entry_q;
              opcode_d = pend_op_q;
              state_d  = ST_EXEC;
`ifdef CALC_CHAIN_EN
              chain_d  = 1'b0;
`endif
            end
          end else if (ev_op) begin
            if (op_legal) begin
              if (state_q == ST_ENTER_A) begin
                alu_a_d   = entry_q;
                pend_op_d = bus.key_op;
                entry_d   = '0;
                cnt_d     = '0;
                neg_d     = 1'b0;
                state_d   = ST_ENTER_B;
              end else if (cnt_q == '0) begin
                pend_op_d = bus.key_op;
              end
`ifdef CALC_CHAIN_EN
              else begin
                alu_b_d   = entry_q;
                opcode_d  = pend_op_q;
                next_op_d = bus.key_op;
                chain_d   = 1'b1;
                state_d   = ST_EXEC;
              end
`endif
            end
          end else if (ev_neg) begin
            entry_d = -entry_q;
            neg_d   = ~neg_q;
          end else if (ev_digit && digit_legal && (cnt_q < CNT_MAX)) begin
            // Digits accumulate away from zero in the direction of the sign.
            entry_d = neg_q ? (entry_q * 16'sd10) - digit_s
                            : (entry_q * 16'sd10) + digit_s;
            cnt_d   = cnt_q + 1'b1;
`ifdef CALC_CHAIN_EN
            show_res_d = 1'b0;
`endif
          end
        end

        ST_EXEC: begin
          if (bus.alu_ovf) begin
            state_d = ST_ERR;
          end else begin
            result_d = bus.alu_out;
            state_d  = ST_SHOW;
`ifdef CALC_CHAIN_EN
            if (chain_q) begin
              alu_a_d    = bus.alu_out;
              pend_op_d  = next_op_q;
              entry_d    = '0;
              cnt_d      = '0;
              neg_d      = 1'b0;
              show_res_d = 1'b1;
              state_d    = ST_ENTER_B;
            end
`endif
          end
`ifdef CALC_CHAIN_EN
          chain_d = 1'b0;
`endif
        end

        ST_SHOW: begin
          if (ev_op) begin
            if (op_legal) begin
              alu_a_d   = result_q;
              pend_op_d = bus.key_op;
              entry_d   = '0;
              cnt_d     = '0;
              neg_d     = 1'b0;
              state_d   = ST_ENTER_B;
            end
          end else if (ev_neg) begin
            // The negated result becomes a full entry, so no digits can be appended.
            entry_d = -result_q;
            cnt_d   = CNT_MAX;
            neg_d   = (result_q > 16'sd0);
            state_d = ST_ENTER_A;
          end else if (ev_digit && digit_legal) begin
            entry_d = digit_s;
            cnt_d   = CNT_W'(1);
            neg_d   = 1'b0;
            state_d = ST_ENTER_A;
          end
        end

        ST_ERR: begin
          // Only clear leaves the error state.
        end

        default: state_d = ST_ENTER_A;
      endcase
    end

    // Display registers follow the next state so they line up with it.
    unique case (state_d)
      ST_ENTER_A, ST_ENTER_B: begin
        disp_d = entry_d;
`ifdef CALC_CHAIN_EN
        if (show_res_d && (cnt_d == '0)) disp_d = result_d;
`endif
      end
      ST_EXEC, ST_SHOW: disp_d = result_d;
      default:          disp_d = '0;
    endcase
    err_d = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ENTER_A;
      entry_q   <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      pend_op_q <= '0;
      result_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      opcode_q  <= '0;
      disp_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      pend_op_q <= pend_op_d;
      result_q  <= result_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      opcode_q  <= opcode_d;
      disp_q    <= disp_d;
      err_q     <= err_d;
    end
  end

`ifdef CALC_CHAIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q    <= 1'b0;
      next_op_q  <= '0;
      show_res_q <= 1'b0;
    end else begin
      chain_q    <= chain_d;
      next_op_q  <= next_op_d;
      show_res_q <= show_res_d;
    end
  end
`endif

  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_opcode = opcode_q;
  assign bus.disp_value = disp_q;
  assign bus.disp_err   = err_q;
  assign bus.busy       = (state_q == ST_EXEC);
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: self-checking bench for calc_ctrl with a behavioural ALU.
module tb_calc_ctrl;

  localparam logic [2:0] S_ENTER_A = 3'd0;
  localparam logic [2:0] S_ENTER_B = 3'd1;
  localparam logic [2:0] S_ERR     = 3'd4;

  logic clk;
  logic rst_n;

  calc_ctrl_if bus ();

  calc_ctrl #(.MAX_DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- ALU model ----------------
  int   alu_r;
  logic alu_e;
  always_comb begin
    alu_r = 0;
    alu_e = 1'b0;
    case (bus.alu_opcode)
      3'd1: alu_r = int'(bus.alu_a) + int'(bus.alu_b);
      3'd2: alu_r = int'(bus.alu_a) - int'(bus.alu_b);
      3'd3: alu_r = int'(bus.alu_a) * int'(bus.alu_b);
      3'd4: begin
        if (bus.alu_b == 16'sd0) alu_e = 1'b1;
        else alu_r = int'(bus.alu_a) / int'(bus.alu_b);
      end
      default: alu_r = 0;
    endcase
    if (alu_r > 9999 || alu_r < -9999) alu_e = 1'b1;
    bus.alu_out = alu_e ? 16'sd0 : 16'(alu_r);
    bus.alu_ovf = alu_e;
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  function automatic void check(input string name, input logic [15:0] act,
                                input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%04h expected=0x%04h", name, act, exp);
    end
  endfunction

  // Scoreboard item: {opcode[3], a[16], b[16], err[1], value[16]}
  logic [51:0] exp_q[$];
  bit          sb_en = 1'b1;
  bit          in_exec = 1'b0;
  int          busy_cycles = 0;
  logic [2:0]  obs_op;
  logic [15:0] obs_a, obs_b;

  task automatic push_exp(input int op, input int a, input int b,
                          input bit err, input int val);
    exp_q.push_back({3'(op), 16'(a), 16'(b), err, 16'(val)});
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      in_exec     = 1'b0;
      busy_cycles = 0;
    end else if (bus.busy) begin
      if (!in_exec) begin
        obs_op = bus.alu_opcode;
        obs_a  = bus.alu_a;
        obs_b  = bus.alu_b;
      end
      in_exec = 1'b1;
      busy_cycles++;
    end else if (in_exec) begin
      in_exec = 1'b0;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_exec", 16'(exp_q.size()), 16'd1);
        end else begin
          logic [51:0] e;
          e = exp_q.pop_front();
          check("exec_opcode", {13'd0, obs_op}, {13'd0, e[51:49]});
          check("exec_alu_a", obs_a, e[48:33]);
          check("exec_alu_b", obs_b, e[32:17]);
          check("exec_busy_len", 16'(busy_cycles), 16'd1);
          check("result_err", {15'd0, bus.disp_err}, {15'd0, e[16]});
          check("result_value", bus.disp_value, e[15:0]);
        end
      end
      busy_cycles = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic press_digit(input int d);
    @(posedge clk); #1;
    bus.key_digit_valid = 1'b1; bus.key_digit = 4'(d);
    @(posedge clk); #1;
    bus.key_digit_valid = 1'b0;
  endtask

  task automatic press_op(input int op);
    @(posedge clk); #1;
    bus.key_op_valid = 1'b1; bus.key_op = 3'(op);
    @(posedge clk); #1;
    bus.key_op_valid = 1'b0;
  endtask

  task automatic press_neg();
    @(posedge clk); #1; bus.key_neg = 1'b1;
    @(posedge clk); #1; bus.key_neg = 1'b0;
  endtask

  task automatic press_eq();
    @(posedge clk); #1; bus.key_eq = 1'b1;
    @(posedge clk); #1; bus.key_eq = 1'b0;
  endtask

  task automatic press_clr();
    @(posedge clk); #1; bus.key_clr = 1'b1;
    @(posedge clk); #1; bus.key_clr = 1'b0;
  endtask

  // Enter a signed value; the sign key goes before or after the digits.
  task automatic enter_num(input int v, input bit neg_first);
    int m, n;
    int digs[4];
    m = (v < 0) ? -v : v;
    n = 0;
    if (m == 0) begin
      digs[0] = 0; n = 1;
    end
    while (m > 0 && n < 4) begin
      digs[n] = m % 10; m = m / 10; n++;
    end
    if (v < 0 && neg_first) press_neg();
    for (int i = n - 1; i >= 0; i--) press_digit(digs[i]);
    if (v < 0 && !neg_first) press_neg();
  endtask

  task automatic wait_sb_empty(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, 16'(exp_q.size()), 16'd0);
  endtask

  typedef struct {
    int         a;
    int         op;
    int         b;
    bit         no_b;
    int         exp_val;
    bit         exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic run_vec(input vec_t v, input bit neg_first);
    press_clr();
    enter_num(v.a, neg_first);
    press_op(v.op);
    if (!v.no_b) enter_num(v.b, neg_first);
    push_exp(v.op, v.a, v.no_b ? 0 : v.b, v.exp_err, v.exp_val);
    press_eq();
    check("busy_after_eq", {15'd0, bus.busy}, 16'd1);
    wait_sb_empty("vec_done");
  endtask

  // ---------------- test ----------------
  initial begin
    rst_n = 1'b0;
    bus.key_digit_valid = 1'b0; bus.key_digit = 4'd0;
    bus.key_neg = 1'b0; bus.key_op_valid = 1'b0; bus.key_op = 3'd0;
    bus.key_eq = 1'b0; bus.key_clr = 1'b0;

    //            a      op  b     no_b  val    err
    vecs[0]  = '{ 12,    1,  34,   1'b0, 46,    1'b0};
    vecs[1]  = '{ 9999,  1,  1,    1'b0, 0,     1'b1};
    vecs[2]  = '{ 5,     4,  0,    1'b1, 0,     1'b1};
    vecs[3]  = '{ -7,    2,  3,    1'b0, -10,   1'b0};
    vecs[4]  = '{ 25,    3,  -4,   1'b0, -100,  1'b0};
    vecs[5]  = '{ -100,  4,  7,    1'b0, -14,   1'b0};
    vecs[6]  = '{ 99,    3,  101,  1'b0, 9999,  1'b0};
    vecs[7]  = '{ 100,   3,  100,  1'b0, 0,     1'b1};
    vecs[8]  = '{ -9999, 2,  1,    1'b0, 0,     1'b1};
    vecs[9]  = '{ 1234,  2,  1234, 1'b0, 0,     1'b0};
    vecs[10] = '{ 7,     4,  -2,   1'b0, -3,    1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_alu_a", bus.alu_a, 16'd0);
    check("rst_alu_b", bus.alu_b, 16'd0);
    check("rst_opcode", {13'd0, bus.alu_opcode}, 16'd0);
    check("rst_disp", bus.disp_value, 16'd0);
    check("rst_err_busy", {14'd0, bus.disp_err, bus.busy}, 16'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_state", {13'd0, bus.dbg_state}, {13'd0, S_ENTER_A});

    // Table-driven operations.
    for (int i = 0; i < 11; i++) run_vec(vecs[i], bit'(i % 2));

    // Digit limit and illegal digit.
    press_clr();
    for (int d = 1; d <= 5; d++) press_digit(d);
    check("max_digits", bus.disp_value, 16'd1234);
    press_clr();
    press_digit(12);
    check("illegal_digit", bus.disp_value, 16'd0);

    // Error state ignores keys until clear.
    run_vec(vecs[1], 1'b0);
    press_digit(5);
    check("err_digit_val", bus.disp_value, 16'd0);
    check("err_digit_flag", {15'd0, bus.disp_err}, 16'd1);
    press_eq();
    check("err_eq_state", {13'd0, bus.dbg_state}, {13'd0, S_ERR});
    press_clr();
    check("clr_from_err_val", bus.disp_value, 16'd0);
    check("clr_from_err_flag", {15'd0, bus.disp_err}, 16'd0);
    check("clr_from_err_state", {13'd0, bus.dbg_state}, {13'd0, S_ENTER_A});

    // Continuing from SHOW.
    run_vec(vecs[0], 1'b0);
    press_op(1);
    check("show_op_state", {13'd0, bus.dbg_state}, {13'd0, S_ENTER_B});
    check("show_op_alu_a", bus.alu_a, 16'd46);
    press_digit(4);
    push_exp(1, 46, 4, 1'b0, 50);
    press_eq();
    wait_sb_empty("show_chain_done");
    press_neg();
    check("show_neg_val", bus.disp_value, 16'(-50));
    check("show_neg_state", {13'd0, bus.dbg_state}, {13'd0, S_ENTER_A});
    press_digit(3);
    check("show_neg_full", bus.disp_value, 16'(-50));
    press_op(2);
    check("show_neg_op_a", bus.alu_a, 16'(-50));
    run_vec(vecs[0], 1'b1);
    press_digit(7);
    check("show_digit_val", bus.disp_value, 16'd7);
    check("show_digit_state", {13'd0, bus.dbg_state}, {13'd0, S_ENTER_A});

    // Operator replaced while B is still empty.
    press_clr();
    press_digit(6);
    press_op(1);
    press_op(2);
    press_digit(2);
    push_exp(2, 6, 2, 1'b0, 4);
    press_eq();
    wait_sb_empty("replace_op_done");

    // Simultaneous pulses: higher priority wins, sign held while entry is 0.
    press_clr();
    press_digit(5);
    @(posedge clk); #1;
    bus.key_op_valid = 1'b1; bus.key_op = 3'd1;
    bus.key_digit_valid = 1'b1; bus.key_digit = 4'd3;
    @(posedge clk); #1;
    bus.key_op_valid = 1'b0; bus.key_digit_valid = 1'b0;
    check("prio_op_state", {13'd0, bus.dbg_state}, {13'd0, S_ENTER_B});
    check("prio_op_disp", bus.disp_value, 16'd0);
    @(posedge clk); #1;
    bus.key_neg = 1'b1; bus.key_digit_valid = 1'b1; bus.key_digit = 4'd9;
    @(posedge clk); #1;
    bus.key_neg = 1'b0; bus.key_digit_valid = 1'b0;
    check("prio_neg_disp", bus.disp_value, 16'd0);
    press_digit(8);
    check("pending_sign", bus.disp_value, 16'(-8));
    push_exp(1, 5, -8, 1'b0, -3);
    press_eq();
    wait_sb_empty("prio_done");

    // Clear in the same cycle as equals.
    press_clr();
    press_digit(1); press_op(1); press_digit(2);
    @(posedge clk); #1;
    bus.key_eq = 1'b1; bus.key_clr = 1'b1;
    @(posedge clk); #1;
    bus.key_eq = 1'b0; bus.key_clr = 1'b0;
    check("clr_eq_busy", {15'd0, bus.busy}, 16'd0);
    check("clr_eq_disp", bus.disp_value, 16'd0);
    check("clr_eq_state", {13'd0, bus.dbg_state}, {13'd0, S_ENTER_A});
    check("clr_eq_opcode", {13'd0, bus.alu_opcode}, 16'd0);

    // Clear during EXEC.
    press_digit(1); press_op(1); press_digit(2);
    sb_en = 1'b0;
    @(posedge clk); #1; bus.key_eq = 1'b1;
    @(posedge clk); #1; bus.key_eq = 1'b0;
    check("exec_busy", {15'd0, bus.busy}, 16'd1);
    check("exec_opcode_add", {13'd0, bus.alu_opcode}, 16'd1);
    bus.key_clr = 1'b1;
    @(posedge clk); #1; bus.key_clr = 1'b0;
    check("clr_exec_busy", {15'd0, bus.busy}, 16'd0);
    check("clr_exec_disp", bus.disp_value, 16'd0);
    check("clr_exec_err", {15'd0, bus.disp_err}, 16'd0);
    check("clr_exec_state", {13'd0, bus.dbg_state}, {13'd0, S_ENTER_A});
    check("clr_exec_alu_a", bus.alu_a, 16'd0);
    @(posedge clk); #1;
    sb_en = 1'b1;

    // Operator after B digits.
    press_clr();
    press_digit(2); press_op(1); press_digit(3);
`ifdef CALC_CHAIN_EN
    push_exp(1, 2, 3, 1'b0, 5);
    press_op(3);
    wait_sb_empty("chain_first_done");
    check("chain_mid_disp", bus.disp_value, 16'd5);
    check("chain_mid_state", {13'd0, bus.dbg_state}, {13'd0, S_ENTER_B});
    press_digit(4);
    check("chain_b_disp", bus.disp_value, 16'd4);
    push_exp(3, 5, 4, 1'b0, 20);
    press_eq();
    wait_sb_empty("chain_final_done");
`else
    press_op(3);
    check("nochain_state", {13'd0, bus.dbg_state}, {13'd0, S_ENTER_B});
    check("nochain_disp", bus.disp_value, 16'd3);
    push_exp(1, 2, 3, 1'b0, 5);
    press_eq();
    wait_sb_empty("nochain_done");
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
